// File: rtl/spi_slave_pkg.sv
// Shared register map, CTRL bit positions and SPI mode helper for the SPI RX slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_slave_pkg;

   localparam logic [2:0] REG_CTRL    = 3'd0;
   localparam logic [2:0] REG_DEST    = 3'd1;
   localparam logic [2:0] REG_BITCNT  = 3'd2;
   localparam logic [2:0] REG_WORDCNT = 3'd3;

   localparam int CTRL_ENABLE    = 0;
   localparam int CTRL_BUSY      = 1;
   localparam int CTRL_OVERFLOW  = 2;
   localparam int CTRL_CPOL      = 3;
   localparam int CTRL_CPHA      = 4;
   localparam int CTRL_LSB_FIRST = 5;
   localparam int CTRL_DONE      = 6;
   localparam int CTRL_IRQ_EN    = 7;

   // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling edge.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return (cpol == cpha);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises one asynchronous SPI pin into clk and flags its rising/falling edges.
// Latency: SYNC_STAGES cycles to lvl; edges flagged in the same cycle lvl changes.
// Backpressure: none; a free-running sampler.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   // Next state: shift the pin through the synchroniser, keep one history flop behind it.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // Reset to the pin's idle level so no edge is reported straight out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         hist_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign lvl  = sync_q[SYNC_STAGES-1];
   assign rise = lvl & ~hist_q;
   assign fall = ~lvl & hist_q;

endmodule

// File: rtl/spi_slave_dma_rx.sv
// SPI receive slave assembling MOSI bits into 32-bit words and streaming them to PSRAM.
// Latency: word pushed on its 32nd sample edge; do_write rises the cycle after the push.
// Backpressure: FIFO_DEPTH-word FIFO absorbs memory stalls; pushes into a full FIFO drop and set overflow.
module spi_slave_dma_rx
   import spi_slave_pkg::*;
#(
   parameter int FIFO_DEPTH  = 512,
   parameter int ADDR_BITS   = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [2:0]           register_num,
   input  logic [31:0]          data_in,
   output logic [31:0]          data_out,
   input  logic                 wen,
   input  logic                 ren,
   output logic                 ready,
   output logic                 irq,
   output logic                 qpimem_iface_do_write,
   input  logic                 qpimem_iface_next_word,
   output logic [ADDR_BITS-1:0] qpimem_iface_addr,
   output logic [31:0]          qpimem_iface_wdata,
   input  logic                 qpimem_iface_is_idle,
   input  logic                 SCK,
   input  logic                 MOSI,
   output logic                 MISO,
   input  logic                 CS
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   // Control/status and datapath state.
   logic                 enable_q, enable_d;
   logic                 overflow_q, overflow_d;
   logic                 cpol_q, cpol_d;
   logic                 cpha_q, cpha_d;
   logic                 lsb_q, lsb_d;
   logic                 done_q, done_d;
   logic                 done_pend_q, done_pend_d;
   logic                 irq_en_q, irq_en_d;
   logic [31:0]          dest_q, dest_d;
   logic [31:0]          bitcnt_q, bitcnt_d;
   logic [31:0]          wordcnt_q, wordcnt_d;
   logic [31:0]          shift_q, shift_d;
   logic [4:0]           nbits_q, nbits_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
   logic [31:0]          data_out_q, data_out_d;
   logic                 ready_q, ready_d;
   logic [31:0]          fifo_mem [FIFO_DEPTH];

   logic        sck_lvl_unused, sck_rise, sck_fall;
   logic        mosi_lvl, mosi_rise_unused, mosi_fall_unused;
   logic        cs_lvl, cs_rise, cs_fall;
   logic        busy_wr_unused, is_idle_unused;
   logic        empty, full, pop, push, wr_en, sample_en;
   logic [31:0] push_word;
   logic [5:0]  pad;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk(clk), .reset_n(reset_n), .din(SCK),
      .lvl(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset_n(reset_n), .din(MOSI),
      .lvl(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   // CS idles high, so its synchroniser resets high to avoid a phantom edge.
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset_n(reset_n), .din(CS),
      .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall));

   assign busy_wr_unused = data_in[CTRL_BUSY];
   assign is_idle_unused = qpimem_iface_is_idle;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop       = qpimem_iface_next_word & ~empty;
   assign sample_en = enable_q & ~cs_lvl &
                      (sample_on_rise(cpol_q, cpha_q) ? sck_rise : sck_fall);
   // Shift distance that aligns a partial word of nbits_q bits.
   assign pad       = 6'd32 - {1'b0, nbits_q};

   // Next-state logic: bus writes, DMA pops, SPI shifting, FIFO pushes and done tracking.
   always_comb begin
      enable_d    = enable_q;
      overflow_d  = overflow_q;
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      lsb_d       = lsb_q;
      done_d      = done_q;
      done_pend_d = done_pend_q;
      irq_en_d    = irq_en_q;
      dest_d      = dest_q;
      bitcnt_d    = bitcnt_q;
      wordcnt_d   = wordcnt_q;
      shift_d     = shift_q;
      nbits_d     = nbits_q;
      addr_d      = addr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      push        = 1'b0;
      push_word   = '0;
      wr_en       = 1'b0;

      if (wen) begin
         case (register_num)
            REG_CTRL: begin
               enable_d = data_in[CTRL_ENABLE];
               irq_en_d = data_in[CTRL_IRQ_EN];
               // Mode bits are frozen while enabled so a live transfer cannot change phase.
               if (!enable_q) begin
                  cpol_d = data_in[CTRL_CPOL];
                  cpha_d = data_in[CTRL_CPHA];
                  lsb_d  = data_in[CTRL_LSB_FIRST];
               end
               if (data_in[CTRL_OVERFLOW]) overflow_d = 1'b0;
               if (data_in[CTRL_DONE])     done_d     = 1'b0;
            end
            REG_DEST: dest_d = {data_in[31:2], 2'b00};
            default: ;
         endcase
      end

      if (pop) begin
         rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(1);
         addr_d    = addr_q + ADDR_BITS'(4);
         wordcnt_d = wordcnt_q + 32'd1;
      end

      if (!enable_q) begin
         shift_d = '0;
         nbits_d = '0;
      end else if (cs_fall) begin
         shift_d     = '0;
         nbits_d     = '0;
         bitcnt_d    = '0;
         wordcnt_d   = '0;
         addr_d      = dest_q[ADDR_BITS-1:0];
         done_pend_d = 1'b0;
         // An empty FIFO is realigned; queued words keep draining otherwise.
         if (empty) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
         end
      end else if (sample_en) begin
         shift_d = lsb_q ? {mosi_lvl, shift_q[31:1]} : {shift_q[30:0], mosi_lvl};
         if (bitcnt_q != '1) bitcnt_d = bitcnt_q + 32'd1;
         if (nbits_q == 5'd31) begin
            push      = 1'b1;
            push_word = shift_d;
            nbits_d   = '0;
         end else begin
            nbits_d = nbits_q + 5'd1;
         end
      end else if (cs_rise) begin
         done_pend_d = 1'b1;
         if (nbits_q != 5'd0) begin
            push      = 1'b1;
            push_word = lsb_q ? (shift_q >> pad) : (shift_q << pad);
            nbits_d   = '0;
            shift_d   = '0;
         end
      end

      // A pop in the same cycle frees the slot even when the FIFO reads full.
      if (push && !overflow_q) begin
         if (!full || pop) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
         end else begin
            overflow_d = 1'b1;
         end
      end

      if (done_pend_q && empty && !wr_en) begin
         done_d      = 1'b1;
         done_pend_d = 1'b0;
      end
   end

   // Bus side: one-cycle ready pulse and registered read data.
   always_comb begin
      ready_d    = wen | ren;
      data_out_d = data_out_q;
      if (ren) begin
         case (register_num)
            REG_CTRL:    data_out_d = {24'd0, irq_en_q, done_q, lsb_q, cpha_q, cpol_q,
                                       overflow_q, ~cs_lvl, enable_q};
            REG_DEST:    data_out_d = dest_q;
            REG_BITCNT:  data_out_d = bitcnt_q;
            REG_WORDCNT: data_out_d = wordcnt_q;
            default:     data_out_d = '0;
         endcase
      end
   end

   // State registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_q    <= 1'b0;
         overflow_q  <= 1'b0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         lsb_q       <= 1'b0;
         done_q      <= 1'b0;
         done_pend_q <= 1'b0;
         irq_en_q    <= 1'b0;
         dest_q      <= '0;
         bitcnt_q    <= '0;
         wordcnt_q   <= '0;
         shift_q     <= '0;
         nbits_q     <= '0;
         addr_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         data_out_q  <= '0;
         ready_q     <= 1'b0;
      end else begin
         enable_q    <= enable_d;
         overflow_q  <= overflow_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         lsb_q       <= lsb_d;
         done_q      <= done_d;
         done_pend_q <= done_pend_d;
         irq_en_q    <= irq_en_d;
         dest_q      <= dest_d;
         bitcnt_q    <= bitcnt_d;
         wordcnt_q   <= wordcnt_d;
         shift_q     <= shift_d;
         nbits_q     <= nbits_d;
         addr_q      <= addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         data_out_q  <= data_out_d;
         ready_q     <= ready_d;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_word;
   end

   assign qpimem_iface_do_write = ~empty;
   assign qpimem_iface_wdata    = fifo_mem[rd_ptr_q[PTR_W-1:0]];
   assign qpimem_iface_addr     = addr_q;
   assign irq                   = done_q & irq_en_q;
   assign data_out              = data_out_q;
   assign ready                 = ready_q;
   assign MISO                  = 1'b0;

endmodule
